// File: rtl/fp_convert_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_convert_arbiter_if
//   Request and result bundle of the FP16 -> FP32 converter arbiter.
//
//   req_valid_in   per-requester request valid
//   req_data_in    per-requester FP16_5 vectors (LENGTH lanes x 16 bits)
//   req_ready_out  one-hot grant / accept back to the requesters
//   res_valid_out  result buffer full
//   res_id_out     requester id of the buffered result
//   res_data_out   buffered FP32_8 vector (LENGTH lanes x 32 bits)
//   res_ready_in   consumer accepts the buffered result
//
//   slave  : arbiter side
//   master : requester / consumer side
// ---------------------------------------------------------------------------
interface fp_convert_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LENGTH  = 8,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                  req_valid_in;
  logic [NUM_REQ-1:0][LENGTH-1:0][15:0] req_data_in;
  logic [NUM_REQ-1:0]                  req_ready_out;
  logic                                res_valid_out;
  logic [IDW-1:0]                      res_id_out;
  logic [LENGTH-1:0][31:0]             res_data_out;
  logic                                res_ready_in;

  modport slave (
    input  req_valid_in, req_data_in, res_ready_in,
    output req_ready_out, res_valid_out, res_id_out, res_data_out
  );

  modport master (
    output req_valid_in, req_data_in, res_ready_in,
    input  req_ready_out, res_valid_out, res_id_out, res_data_out
  );
endinterface

// File: rtl/fp_convert_arbiter.sv
// ---------------------------------------------------------------------------
// fp_convert_arbiter
//   Round-robin arbiter and sequencer sharing one FP16_5 -> FP32_8 vector
//   converter among NUM_REQ requesters. One request vector is accepted at a
//   time, held on the converter input for CONV_LAT cycles, and the converter
//   output is captured into a one-entry result buffer tagged with the id of
//   the requester. Lane data passes through bit-exactly.
//
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   bus             request / result handshakes (fp_convert_arbiter_if.slave)
//   conv_data_out   operand to the converter data_in
//   conv_data_in    converter data_out
//   busy_out        high whenever a transaction is in flight or buffered
//   done_count_out  number of results popped (wraps)
//   debugen_in      enables a per-capture trace line in simulation
// ---------------------------------------------------------------------------
module fp_convert_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LENGTH   = 8,
  parameter int CONV_LAT = 0,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  fp_convert_arbiter_if.slave     bus,
  output logic [LENGTH-1:0][15:0] conv_data_out,
  input  logic [LENGTH-1:0][31:0] conv_data_in,
  output logic                    busy_out,
  output logic [31:0]             done_count_out,
  input  logic                    debugen_in
);

  typedef enum logic [1:0] {IDLE, CONV, FULL} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDW-1:0]          last_grant;
  logic [IDW-1:0]          id_reg;
  logic [IDW-1:0]          gnt_idx;
  logic [IDW-1:0]          cand;
  logic [NUM_REQ-1:0]      gnt_onehot;
  logic                    gnt_found;
  logic [LENGTH-1:0][15:0] op_reg;
  logic [7:0]              cnt;
  logic                    res_valid;
  logic [IDW-1:0]          res_id;
  logic [LENGTH-1:0][31:0] res_data;
  logic [31:0]             done_cnt;
  logic                    capture;
  logic                    pop;

  // Rotating priority scan starting just after the last granted requester.
  // The grant is offered only while idle and out of reset, so a requester
  // that drops valid before being served keeps its place in the rotation.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_found  = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && bus.req_valid_in[cand]) begin
        gnt_found        = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
    if (state != IDLE || !reset) begin
      gnt_onehot = '0;
      gnt_found  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_found) begin
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == 8'd0) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.res_ready_in) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept: latch the granted operand; it stays on the converter input
  // until the next accept, which covers a registered converter's latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IDW'(NUM_REQ - 1);
      op_reg     <= '0;
      id_reg     <= '0;
      cnt        <= '0;
    end else begin
      if (gnt_found) begin
        op_reg     <= bus.req_data_in[gnt_idx];
        id_reg     <= gnt_idx;
        last_grant <= gnt_idx;
        cnt        <= 8'(CONV_LAT);
      end else if (state == CONV && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // Capture / pop: one-entry result buffer and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      done_cnt  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_id    <= id_reg;
        res_data  <= conv_data_in;
      end else if (pop) begin
        res_valid <= 1'b0;
        done_cnt  <= done_cnt + 32'd1;
      end
    end
  end

  assign bus.req_ready_out = gnt_onehot;
  assign bus.res_valid_out = res_valid;
  assign bus.res_id_out    = res_id;
  assign bus.res_data_out  = res_data;
  assign conv_data_out     = op_reg;
  assign busy_out          = (state != IDLE);
  assign done_count_out    = done_cnt;

`ifndef SYNTHESIS
  // Simulation-only trace of each captured conversion.
  always @(posedge clk) begin
    if (reset && capture && debugen_in) begin
      $write("fp_convert_arbiter: id=%0d op=%h res=%h\n", id_reg, op_reg, conv_data_in);
    end
  end
`endif

endmodule

// File: tb/tb_fp_convert_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_convert_arbiter
//   Bench for fp_convert_arbiter. Two instances share clock and reset: u_dut0
//   with a combinational converter (CONV_LAT=0) and u_dut1 with a registered
//   converter (CONV_LAT=1). The converter itself is a behavioural FP16->FP32
//   model in the bench.
// ---------------------------------------------------------------------------
module tb_fp_convert_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LENGTH  = 8;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debugen = 1'b0;
  always #5 clk = ~clk;

  fp_convert_arbiter_if #(.NUM_REQ(NUM_REQ), .LENGTH(LENGTH), .IDW(IDW)) ifc0 ();
  fp_convert_arbiter_if #(.NUM_REQ(NUM_REQ), .LENGTH(LENGTH), .IDW(IDW)) ifc1 ();

  logic [LENGTH-1:0][15:0] conv0_op, conv1_op;
  logic [LENGTH-1:0][31:0] conv0_res;
  logic [LENGTH-1:0][31:0] conv1_res = '0;
  logic        busy0, busy1;
  logic [31:0] done0, done1;

  fp_convert_arbiter #(.NUM_REQ(NUM_REQ), .LENGTH(LENGTH), .CONV_LAT(0), .IDW(IDW)) u_dut0 (
    .clk(clk), .reset(reset), .bus(ifc0), .conv_data_out(conv0_op), .conv_data_in(conv0_res),
    .busy_out(busy0), .done_count_out(done0), .debugen_in(debugen));

  fp_convert_arbiter #(.NUM_REQ(NUM_REQ), .LENGTH(LENGTH), .CONV_LAT(1), .IDW(IDW)) u_dut1 (
    .clk(clk), .reset(reset), .bus(ifc1), .conv_data_out(conv1_op), .conv_data_in(conv1_res),
    .busy_out(busy1), .done_count_out(done1), .debugen_in(debugen));

  // Behavioural FP16_5 -> FP32_8 conversion (exact; every FP16 value fits).
  function automatic logic [31:0] h2f(input logic [15:0] h);
    logic [9:0]  m;
    logic [31:0] t;
    int          p;
    if (h[14:10] == 5'h1F) return {h[15], 8'hFF, h[9:0], 13'd0};
    if (h[14:10] != 5'h00) return {h[15], 8'(h[14:10]) + 8'd112, h[9:0], 13'd0};
    if (h[9:0] == 10'd0)   return {h[15], 31'd0};
    m = h[9:0];
    p = 9;
    while (m[9] == 1'b0) begin
      m = m << 1;
      p--;
    end
    t = 32'(h[9:0]) << (23 - p);
    return {h[15], 8'(p + 103), t[22:0]};
  endfunction

  function automatic logic [LENGTH-1:0][31:0] vec_h2f(input logic [LENGTH-1:0][15:0] v);
    logic [LENGTH-1:0][31:0] r;
    for (int l = 0; l < LENGTH; l++) r[l] = h2f(v[l]);
    return r;
  endfunction

  always_comb conv0_res = vec_h2f(conv0_op);
  always @(posedge clk) conv1_res <= vec_h2f(conv1_op);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [LENGTH-1:0][15:0] mk16(input logic [15:0] a, input logic [15:0] b);
    logic [LENGTH-1:0][15:0] r;
    for (int l = 0; l < LENGTH; l++) r[l] = (l == 1) ? b : a;
    return r;
  endfunction

  function automatic logic [LENGTH-1:0][31:0] mk32(input logic [31:0] a, input logic [31:0] b);
    logic [LENGTH-1:0][31:0] r;
    for (int l = 0; l < LENGTH; l++) r[l] = (l == 1) ? b : a;
    return r;
  endfunction

  function automatic logic [15:0] rnd_half();
    logic [15:0] h = 16'($urandom);
    if ($urandom_range(0, 3) == 0) h[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00;
    return h;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Returns the number of sampling points until res_valid is seen (0 = timeout).
  task automatic wait_res(input int which, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if ((which == 0) ? ifc0.res_valid_out : ifc1.res_valid_out) begin
        n = i;
        break;
      end
    end
  endtask

  int gidx[8];
  int gcyc[8];

  // Samples the current cycle first, then subsequent ones, on u_dut0.
  task automatic collect_grants(input int n);
    int got = 0;
    int cyc = 0;
    for (int k = 0; k < 8; k++) begin gidx[k] = -1; gcyc[k] = -1; end
    while (got < n && cyc < 60) begin
      #1;
      if (ifc0.req_ready_out != '0) begin
        gidx[got] = onehot_idx(ifc0.req_ready_out);
        gcyc[got] = cyc;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] l0;
    logic [15:0] l1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_done;
    logic [NUM_REQ-1:0]      want;
    logic [NUM_REQ-1:0]      exp_g;
    int                      m_last, m_id, m_vis, m_count, cyc, gsel;
    bit                      m_out;
    logic [LENGTH-1:0][31:0] m_data;
    logic [LENGTH-1:0][15:0] m_op;
    logic [LENGTH-1:0][15:0] bp_op;
    logic [LENGTH-1:0][31:0] bp_res;

    tbl[0] = '{1, 16'h3C00, 16'hC000, 32'h3F80_0000, 32'hC000_0000};
    tbl[1] = '{3, 16'h7C00, 16'hFC00, 32'h7F80_0000, 32'hFF80_0000};
    tbl[2] = '{0, 16'h0000, 16'h8000, 32'h0000_0000, 32'h8000_0000};
    tbl[3] = '{2, 16'h0001, 16'h0400, 32'h3380_0000, 32'h3880_0000};
    tbl[4] = '{1, 16'h7BFF, 16'h7E00, 32'h477F_E000, 32'h7FC0_0000};
    tbl[5] = '{3, 16'h4200, 16'hB800, 32'h4040_0000, 32'hBF00_0000};

    ifc0.req_valid_in = '1;
    ifc0.req_data_in  = '0;
    ifc0.res_ready_in = 1'b0;
    ifc1.req_valid_in = '1;
    ifc1.req_data_in  = '0;
    ifc1.res_ready_in = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #10;
    chk("rst_res_valid", 256'(ifc0.res_valid_out), 256'(0));
    chk("rst_res_id", 256'(ifc0.res_id_out), 256'(0));
    chk("rst_res_data", 256'(ifc0.res_data_out), 256'(0));
    chk("rst_conv_data", 256'(conv0_op), 256'(0));
    chk("rst_req_ready", 256'(ifc0.req_ready_out), 256'(0));
    chk("rst_busy", 256'(busy0), 256'(0));
    chk("rst_done", 256'(done0), 256'(0));
    chk("rst1_busy", 256'(busy1), 256'(0));
    chk("rst1_req_ready", 256'(ifc1.req_ready_out), 256'(0));
    ifc0.req_valid_in = '0;
    ifc1.req_valid_in = '0;
    @(negedge clk);
    reset = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    debugen = 1'b1;
    ifc0.req_valid_in = 4'b0100;
    ifc0.req_data_in[2] = mk16(16'h3C00, 16'h3C00);
    ifc0.res_ready_in = 1'b1;
    #1;
    chk("single_grant", 256'(ifc0.req_ready_out), 256'(4'b0100));
    @(posedge clk); #1;
    ifc0.req_valid_in = '0;
    wait_res(0, n);
    chk("single_latency", 256'(n), 256'(2));
    chk("single_id", 256'(ifc0.res_id_out), 256'(2));
    chk("single_data", 256'(ifc0.res_data_out), 256'(mk32(32'h3F80_0000, 32'h3F80_0000)));
    @(posedge clk); #1;
    chk("single_done", 256'(done0), 256'(1));
    chk("single_popped", 256'(ifc0.res_valid_out), 256'(0));
    debugen = 1'b0;
    exp_done = 1;

    // Table-driven single transactions
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ifc0.req_valid_in = '0;
      ifc0.req_valid_in[tbl[t].id] = 1'b1;
      ifc0.req_data_in[tbl[t].id] = mk16(tbl[t].l0, tbl[t].l1);
      ifc0.res_ready_in = 1'b1;
      #1;
      chk("tbl_grant", 256'(ifc0.req_ready_out), 256'(4'b0001 << tbl[t].id));
      @(posedge clk); #1;
      ifc0.req_valid_in = '0;
      wait_res(0, n);
      chk("tbl_latency", 256'(n), 256'(2));
      chk("tbl_id", 256'(ifc0.res_id_out), 256'(tbl[t].id));
      chk("tbl_data", 256'(ifc0.res_data_out), 256'(mk32(tbl[t].e0, tbl[t].e1)));
      @(posedge clk); #1;
      exp_done++;
      chk("tbl_done", 256'(done0), 256'(exp_done));
    end

    // Reset in CONV, then rotation from requester 0
    for (int i = 0; i < NUM_REQ; i++) ifc0.req_data_in[i] = mk16(16'h3C00 + 16'(i), 16'h4000);
    @(negedge clk);
    ifc0.req_valid_in = 4'b0100;
    ifc0.res_ready_in = 1'b1;
    @(posedge clk); #2;
    chk("midrst_busy_before", 256'(busy0), 256'(1));
    reset = 1'b0;
    #1;
    chk("midrst_res_valid", 256'(ifc0.res_valid_out), 256'(0));
    chk("midrst_busy", 256'(busy0), 256'(0));
    chk("midrst_done", 256'(done0), 256'(0));
    chk("midrst_ready", 256'(ifc0.req_ready_out), 256'(0));
    @(negedge clk);
    @(negedge clk);
    ifc0.req_valid_in = 4'b1111;
    reset = 1'b1;
    collect_grants(6);
    for (int k = 0; k < 6; k++) begin
      chk("rot_order", 256'(gidx[k]), 256'(k % NUM_REQ));
      if (k > 0) chk("rot_gap", 256'(gcyc[k] - gcyc[k-1]), 256'(3));
    end
    @(negedge clk);
    ifc0.req_valid_in = '0;
    repeat (5) @(negedge clk);

    // Priority skip: last grant 1, only 0 and 3 valid
    do_reset();
    ifc0.req_valid_in = 4'b0010;
    ifc0.res_ready_in = 1'b1;
    #1;
    chk("skip_setup_grant", 256'(ifc0.req_ready_out), 256'(4'b0010));
    @(posedge clk); #1;
    ifc0.req_valid_in = '0;
    repeat (4) @(negedge clk);
    ifc0.req_valid_in = 4'b1001;
    collect_grants(2);
    chk("skip_first", 256'(gidx[0]), 256'(3));
    chk("skip_second", 256'(gidx[1]), 256'(0));
    @(negedge clk);
    ifc0.req_valid_in = '0;
    repeat (5) @(negedge clk);

    // Backpressure on the registered-converter instance
    do_reset();
    bp_op = '0;
    bp_op[0] = 16'hC000;
    bp_op[1] = 16'h7C00;
    bp_res = '0;
    bp_res[0] = 32'hC000_0000;
    bp_res[1] = 32'h7F80_0000;
    ifc1.req_data_in[0] = bp_op;
    ifc1.req_valid_in = 4'b0001;
    ifc1.res_ready_in = 1'b0;
    #1;
    chk("bp_grant", 256'(ifc1.req_ready_out), 256'(4'b0001));
    @(posedge clk); #1;
    ifc1.req_valid_in = 4'b1111;
    wait_res(1, n);
    chk("bp_latency", 256'(n), 256'(3));
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk("bp_hold_valid", 256'(ifc1.res_valid_out), 256'(1));
      chk("bp_hold_data", 256'(ifc1.res_data_out), 256'(bp_res));
      chk("bp_hold_ready", 256'(ifc1.req_ready_out), 256'(0));
    end
    @(negedge clk);
    ifc1.res_ready_in = 1'b1;
    #1;
    chk("bp_pop_valid", 256'(ifc1.res_valid_out), 256'(1));
    @(posedge clk); #1;
    chk("bp_popped", 256'(ifc1.res_valid_out), 256'(0));
    chk("bp_done", 256'(done1), 256'(1));
    chk("bp_next_grant", 256'(ifc1.req_ready_out), 256'(4'b0010));
    ifc1.req_valid_in = '0;
    ifc1.res_ready_in = 1'b0;

    // Completion counter wrap
    @(negedge clk);
    ifc0.req_data_in[0] = mk16(16'h3C00, 16'h3C00);
    ifc0.req_valid_in = 4'b0001;
    ifc0.res_ready_in = 1'b0;
    @(posedge clk); #1;
    ifc0.req_valid_in = '0;
    wait_res(0, n);
    chk("wrap_latency", 256'(n), 256'(2));
    force u_dut0.done_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut0.done_cnt;
    ifc0.res_ready_in = 1'b1;
    @(posedge clk); #1;
    chk("wrap_done", 256'(done0), 256'(0));
    chk("wrap_popped", 256'(ifc0.res_valid_out), 256'(0));

    // Randomized traffic against a transaction-level reference
    do_reset();
    want    = '0;
    m_last  = NUM_REQ - 1;
    m_out   = 1'b0;
    m_count = 0;
    m_vis   = 0;
    m_id    = 0;
    m_data  = '0;
    m_op    = '0;
    cyc     = 0;
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!want[i] && $urandom_range(0, 4) == 0) want[i] = 1'b1;
        ifc0.req_valid_in[i] = want[i] && ($urandom_range(0, 3) != 0);
        for (int l = 0; l < LENGTH; l++) ifc0.req_data_in[i][l] = rnd_half();
      end
      ifc0.res_ready_in = ($urandom_range(0, 2) != 0);
      #1;
      cyc++;
      exp_g = '0;
      gsel  = -1;
      if (!m_out) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (gsel < 0 && ifc0.req_valid_in[(m_last + k) % NUM_REQ]) gsel = (m_last + k) % NUM_REQ;
        end
        if (gsel >= 0) exp_g[gsel] = 1'b1;
      end
      chk("rnd_ready", 256'(ifc0.req_ready_out), 256'(exp_g));
      chk("rnd_valid", 256'(ifc0.res_valid_out), 256'(m_out && cyc >= m_vis));
      chk("rnd_busy", 256'(busy0), 256'(m_out));
      chk("rnd_done", 256'(done0), 256'(m_count));
      if (m_out) chk("rnd_conv_op", 256'(conv0_op), 256'(m_op));
      if (m_out && cyc >= m_vis) begin
        chk("rnd_id", 256'(ifc0.res_id_out), 256'(m_id));
        chk("rnd_data", 256'(ifc0.res_data_out), 256'(m_data));
        if (ifc0.res_ready_in) begin
          m_out = 1'b0;
          m_count++;
        end
      end else if (gsel >= 0) begin
        m_out  = 1'b1;
        m_last = gsel;
        m_id   = gsel;
        m_op   = ifc0.req_data_in[gsel];
        m_data = vec_h2f(ifc0.req_data_in[gsel]);
        m_vis  = cyc + 2;
        want[gsel] = ($urandom_range(0, 1) == 1);
      end
    end
    ifc0.req_valid_in = '0;
    ifc0.res_ready_in = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
